// File: rtl/fht_stream_ctrl.sv
// Frame sequencer for fht_top: loads one frame of ADC samples round-robin
// into the four FHT banks, kicks the transform, waits for completion and
// streams the result out in natural order (undoing bit-reversed addressing).
module fht_stream_ctrl #(
    parameter int D_BIT  = 16,
    parameter int A_BIT  = 8,
    parameter int RD_LAT = 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iGO,
    input  logic             iADC_VALID,
    input  logic [D_BIT-2:0] iADC_DATA,
    output logic             oADC_READY,
    output logic [3:0]       oFHT_WE,
    output logic [D_BIT-1:0] oFHT_DATA,
    output logic [A_BIT-1:0] oFHT_ADDR_WR,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    output logic [A_BIT-1:0] oFHT_ADDR_RD,
    input  logic [D_BIT-1:0] iFHT_DATA_0,
    input  logic [D_BIT-1:0] iFHT_DATA_1,
    input  logic [D_BIT-1:0] iFHT_DATA_2,
    input  logic [D_BIT-1:0] iFHT_DATA_3,
    output logic             oOUT_VALID,
    output logic [D_BIT-1:0] oOUT_DATA,
    output logic             oOUT_LAST,
    input  logic             iOUT_READY,
    output logic             oBUSY,
    output logic             oDONE
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_LOW  = 3'd3,
        S_WAIT_HIGH = 3'd4,
        S_FETCH     = 3'd5,
        S_EMIT      = 3'd6
    } state_e;

    // Reverse the bit order of a bank address.
    function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] v);
        logic [A_BIT-1:0] res;
        res = {A_BIT{1'b0}};
        for (int i = 0; i < A_BIT; i++) begin
            res[i] = v[A_BIT-1-i];
        end
        return res;
    endfunction

    state_e           state_q, state_d;
    logic [A_BIT+1:0] k_q, k_d;
    logic [A_BIT-1:0] r_q, r_d;
    logic [1:0]       lat_q, lat_d;
    logic [1:0]       b_q, b_d;
    logic [D_BIT-1:0] hold_q [4];
    logic [D_BIT-1:0] hold_d [4];
    logic [3:0]       we_q, we_d;
    logic [D_BIT-1:0] wdata_q, wdata_d;
    logic [A_BIT-1:0] waddr_q, waddr_d;
    logic             start_q, start_d;
    logic [A_BIT-1:0] raddr_q, raddr_d;
    logic             ovalid_q, ovalid_d;
    logic [D_BIT-1:0] odata_q, odata_d;
    logic             olast_q, olast_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic [A_BIT-1:0] r_next_s;

    assign r_next_s = r_q + A_BIT'(1);

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        r_d      = r_q;
        lat_d    = lat_q;
        b_d      = b_q;
        hold_d   = hold_q;
        we_d     = 4'b0000;
        wdata_d  = wdata_q;
        waddr_d  = waddr_q;
        start_d  = 1'b0;
        raddr_d  = raddr_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        olast_d  = olast_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iGO) begin
                    state_d = S_LOAD;
                    k_d     = {(A_BIT+2){1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (ready_q && iADC_VALID) begin
                    we_d    = 4'b0001 << k_q[1:0];
                    waddr_d = k_q[A_BIT+1:2];
                    wdata_d = {iADC_DATA[D_BIT-2], iADC_DATA};
                    k_d     = k_q + (A_BIT+2)'(1);
                    if (k_q == {(A_BIT+2){1'b1}}) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            // The pulse is registered, so it appears one cycle after the
            // last write strobe rather than on top of it.
            S_START: begin
                start_d = 1'b1;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!iFHT_RDY) begin
                    state_d = S_WAIT_HIGH;
                end else begin
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_HIGH: begin
                if (iFHT_RDY) begin
                    state_d = S_FETCH;
                    r_d     = {A_BIT{1'b0}};
                    raddr_d = bitrev({A_BIT{1'b0}});
                    lat_d   = 2'd0;
                end else begin
                    state_d = S_WAIT_HIGH;
                end
            end
            S_FETCH: begin
                if (lat_q == 2'(RD_LAT)) begin
                    hold_d[0] = iFHT_DATA_0;
                    hold_d[1] = iFHT_DATA_1;
                    hold_d[2] = iFHT_DATA_2;
                    hold_d[3] = iFHT_DATA_3;
                    b_d       = 2'd0;
                    ovalid_d  = 1'b1;
                    odata_d   = iFHT_DATA_0;
                    olast_d   = 1'b0;
                    state_d   = S_EMIT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_EMIT: begin
                if (ovalid_q && iOUT_READY) begin
                    if (b_q == 2'd3) begin
                        ovalid_d = 1'b0;
                        olast_d  = 1'b0;
                        if (r_q == {A_BIT{1'b1}}) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            r_d     = r_next_s;
                            raddr_d = bitrev(r_next_s);
                            lat_d   = 2'd0;
                            state_d = S_FETCH;
                        end
                    end else begin
                        b_d     = b_q + 2'd1;
                        odata_d = hold_q[b_q + 2'd1];
                        olast_d = (b_q == 2'd2) && (r_q == {A_BIT{1'b1}});
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d != S_IDLE);
    end

    // State, counter and output registers; reset aborts any frame at once.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q  <= S_IDLE;
            k_q      <= {(A_BIT+2){1'b0}};
            r_q      <= {A_BIT{1'b0}};
            lat_q    <= 2'd0;
            b_q      <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= {D_BIT{1'b0}};
            end
            we_q     <= 4'b0000;
            wdata_q  <= {D_BIT{1'b0}};
            waddr_q  <= {A_BIT{1'b0}};
            start_q  <= 1'b0;
            raddr_q  <= {A_BIT{1'b0}};
            ovalid_q <= 1'b0;
            odata_q  <= {D_BIT{1'b0}};
            olast_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            r_q      <= r_d;
            lat_q    <= lat_d;
            b_q      <= b_d;
            hold_q   <= hold_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            waddr_q  <= waddr_d;
            start_q  <= start_d;
            raddr_q  <= raddr_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign oADC_READY   = ready_q;
    assign oFHT_WE      = we_q;
    assign oFHT_DATA    = wdata_q;
    assign oFHT_ADDR_WR = waddr_q;
    assign oFHT_START   = start_q;
    assign oFHT_ADDR_RD = raddr_q;
    assign oOUT_VALID   = ovalid_q;
    assign oOUT_DATA    = odata_q;
    assign oOUT_LAST    = olast_q;
    assign oBUSY        = busy_q;
    assign oDONE        = done_q;

endmodule

// File: tb/tb_fht_stream_ctrl.sv
// Directed bench for fht_stream_ctrl with a small FHT bank/ready model.
module tb_fht_stream_ctrl;

    localparam int D_BIT  = 16;
    localparam int A_BIT  = 3;
    localparam int RD_LAT = 2;

    logic        clk;
    logic        iRESET, iGO, iADC_VALID, iOUT_READY;
    logic [14:0] iADC_DATA;
    logic        oADC_READY, oFHT_START, oOUT_VALID, oOUT_LAST, oBUSY, oDONE;
    logic [3:0]  oFHT_WE;
    logic [15:0] oFHT_DATA, oOUT_DATA;
    logic [2:0]  oFHT_ADDR_WR, oFHT_ADDR_RD;
    logic        iFHT_RDY;
    logic [15:0] iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2, iFHT_DATA_3;

    fht_stream_ctrl #(.D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT)) dut (
        .iCLK(clk), .iRESET(iRESET), .iGO(iGO),
        .iADC_VALID(iADC_VALID), .iADC_DATA(iADC_DATA), .oADC_READY(oADC_READY),
        .oFHT_WE(oFHT_WE), .oFHT_DATA(oFHT_DATA), .oFHT_ADDR_WR(oFHT_ADDR_WR),
        .oFHT_START(oFHT_START), .iFHT_RDY(iFHT_RDY), .oFHT_ADDR_RD(oFHT_ADDR_RD),
        .iFHT_DATA_0(iFHT_DATA_0), .iFHT_DATA_1(iFHT_DATA_1),
        .iFHT_DATA_2(iFHT_DATA_2), .iFHT_DATA_3(iFHT_DATA_3),
        .oOUT_VALID(oOUT_VALID), .oOUT_DATA(oOUT_DATA), .oOUT_LAST(oOUT_LAST),
        .iOUT_READY(iOUT_READY), .oBUSY(oBUSY), .oDONE(oDONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- FHT model: ready timing and bank read pipeline ----------
    int fcnt = 0;
    assign iFHT_RDY = (fcnt < 3);

    // RDY high 2 cycles after START, then low 20 cycles, then high again.
    always @(posedge clk) begin
        if (oFHT_START) fcnt <= 1;
        else if (fcnt != 0 && fcnt != 22) fcnt <= fcnt + 1;
        else fcnt <= 0;
    end

    logic [2:0] ap0 = 3'd0, ap1 = 3'd0;
    // Two-stage read address pipeline giving RD_LAT = 2.
    always @(posedge clk) begin
        ap0 <= oFHT_ADDR_RD;
        ap1 <= ap0;
    end
    assign iFHT_DATA_0 = {8'h5A, 3'd0, ap1, 2'd0};
    assign iFHT_DATA_1 = {8'h5A, 3'd0, ap1, 2'd1};
    assign iFHT_DATA_2 = {8'h5A, 3'd0, ap1, 2'd2};
    assign iFHT_DATA_3 = {8'h5A, 3'd0, ap1, 2'd3};

    // ---------------- write/start monitor ------------------------------------
    int cyc = 0, wr_cnt = 0, start_cnt = 0, start_cyc = 0, coinc = 0, bad_we = 0;
    logic [15:0] img [4][8];
    logic [3:0]  we_log [32];
    logic [2:0]  wa_log [32];
    logic [15:0] wd_log [32];

    // Record bank writes into a RAM image and count strobes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (oFHT_START) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
            if (oFHT_WE != 4'd0) coinc <= coinc + 1;
        end
        if (oFHT_WE != 4'd0) begin
            wr_cnt <= wr_cnt + 1;
            if ($countones(oFHT_WE) != 1) bad_we <= bad_we + 1;
            if (wr_cnt < 32) begin
                we_log[wr_cnt] <= oFHT_WE;
                wa_log[wr_cnt] <= oFHT_ADDR_WR;
                wd_log[wr_cnt] <= oFHT_DATA;
            end
            for (int b = 0; b < 4; b++) begin
                if (oFHT_WE[b]) img[b][oFHT_ADDR_WR] <= oFHT_DATA;
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    logic [14:0] samp [32];
    logic [2:0]  exp_addr [8];

    task automatic go_pulse();
        iGO = 1'b1;
        @(posedge clk); #1;
        iGO = 1'b0;
    endtask

    task automatic send_samples(input int n, input bit gappy, input bit go_mid);
        int sent = 0;
        int guard = 0;
        bit hs;
        while (sent < n && guard < 2000) begin
            iADC_VALID = !gappy || (guard % 3 == 0);
            iADC_DATA  = samp[sent];
            iGO        = go_mid && (guard == 5);
            hs = iADC_VALID && oADC_READY;
            @(posedge clk); #1;
            guard++;
            if (hs) sent++;
        end
        iADC_VALID = 1'b0;
        iGO        = 1'b0;
        check_eq("samples_sent", 64'(sent), 64'(n));
    endtask

    task automatic check_image();
        for (int i = 0; i < 32; i++) begin
            check_eq($sformatf("img_%0d", i), 64'(img[i % 4][i / 4]), 64'({samp[i][14], samp[i]}));
        end
    endtask

    task automatic drain(input bit toggle, output int first_valid);
        int n = 0;
        int guard = 0;
        int done_early = 0;
        bit prev_stall = 1'b0;
        logic [15:0] prev = 16'd0;
        logic [15:0] exp_w;
        first_valid = -1;
        iOUT_READY = 1'b1;
        while (n < 32 && guard < 2000) begin
            if (prev_stall) begin
                check_eq("stall_valid", 64'(oOUT_VALID), 64'd1);
                check_eq("stall_data", 64'(oOUT_DATA), 64'(prev));
            end
            if (oDONE) done_early++;
            if (oOUT_VALID && first_valid < 0) first_valid = cyc;
            prev_stall = oOUT_VALID && !iOUT_READY;
            prev = oOUT_DATA;
            if (oOUT_VALID && iOUT_READY) begin
                exp_w = {8'h5A, 3'd0, exp_addr[n / 4], 2'(n % 4)};
                check_eq($sformatf("word_%0d", n), 64'(oOUT_DATA), 64'(exp_w));
                check_eq($sformatf("last_%0d", n), 64'(oOUT_LAST), 64'(n == 31));
                if (n % 4 == 0) check_eq($sformatf("raddr_%0d", n / 4), 64'(oFHT_ADDR_RD), 64'(exp_addr[n / 4]));
                n++;
            end
            @(posedge clk); #1;
            guard++;
            if (toggle) iOUT_READY = !iOUT_READY;
        end
        check_eq("drain_count", 64'(n), 64'd32);
        check_eq("done_early", 64'(done_early), 64'd0);
        check_eq("done_pulse", 64'(oDONE), 64'd1);
        check_eq("idle_busy", 64'(oBUSY), 64'd0);
        check_eq("idle_valid", 64'(oOUT_VALID), 64'd0);
        @(posedge clk); #1;
        check_eq("done_one_cycle", 64'(oDONE), 64'd0);
        iOUT_READY = 1'b0;
    endtask

    // ---------------- main sequence ------------------------------------------
    initial begin
        int w0, s0, c0, fv;
        exp_addr = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
        for (int k = 0; k < 32; k++) samp[k] = 15'(k);
        samp[6] = 15'h7FFD;
        samp[7] = 15'h3FFF;
        iRESET = 1'b1; iGO = 1'b0; iADC_VALID = 1'b0; iADC_DATA = 15'd0; iOUT_READY = 1'b0;

        // Scenario 1..4: reset, full frame, start, wait, natural-order output
        repeat (3) @(posedge clk);
        #1;
        iRESET = 1'b0;
        check_eq("reset_outputs", {oADC_READY, oFHT_WE, oFHT_DATA, oFHT_ADDR_WR, oFHT_START,
                 oFHT_ADDR_RD, oOUT_VALID, oOUT_DATA, oOUT_LAST, oBUSY, oDONE}, 64'd0);
        w0 = wr_cnt; s0 = start_cnt; c0 = coinc;
        go_pulse();
        check_eq("load_ready", 64'(oADC_READY), 64'd1);
        check_eq("load_busy", 64'(oBUSY), 64'd1);
        send_samples(32, 1'b0, 1'b0);
        drain(1'b1, fv);
        check_eq("s1_writes", 64'(wr_cnt - w0), 64'd32);
        check_eq("s1_starts", 64'(start_cnt - s0), 64'd1);
        check_eq("s1_coincident", 64'(coinc - c0), 64'd0);
        check_eq("onehot_we", 64'(bad_we), 64'd0);
        check_eq("we_sample5", 64'(we_log[5]), 64'h2);
        check_eq("waddr_sample5", 64'(wa_log[5]), 64'd1);
        check_eq("wdata_sample5", 64'(wd_log[5]), 64'd5);
        check_eq("wdata_neg", 64'(wd_log[6]), 64'hFFFD);
        check_eq("wdata_pos_max", 64'(wd_log[7]), 64'h3FFF);
        check_eq("first_valid_delay", 64'(fv - start_cyc), 64'd27);
        check_image();

        // Scenario 5: gappy valid with a stray iGO during LOAD
        for (int i = 0; i < 32; i++) img[i % 4][i / 4] = 16'hDEAD;
        w0 = wr_cnt; s0 = start_cnt;
        go_pulse();
        send_samples(32, 1'b1, 1'b1);
        drain(1'b0, fv);
        check_eq("s5_writes", 64'(wr_cnt - w0), 64'd32);
        check_eq("s5_starts", 64'(start_cnt - s0), 64'd1);
        check_image();

        // Scenario 6: reset after sample 10 aborts the frame
        go_pulse();
        send_samples(11, 1'b0, 1'b0);
        iRESET = 1'b1;
        iADC_VALID = 1'b1;
        @(posedge clk); #1;
        iRESET = 1'b0;
        iADC_VALID = 1'b0;
        check_eq("abort_ready", 64'(oADC_READY), 64'd0);
        check_eq("abort_we", 64'(oFHT_WE), 64'd0);
        check_eq("abort_busy", 64'(oBUSY), 64'd0);
        check_eq("abort_start", 64'(oFHT_START), 64'd0);
        w0 = wr_cnt; s0 = start_cnt;
        repeat (30) @(posedge clk);
        #1;
        check_eq("abort_no_writes", 64'(wr_cnt - w0), 64'd0);
        check_eq("abort_no_start", 64'(start_cnt - s0), 64'd0);
        w0 = wr_cnt; s0 = start_cnt;
        go_pulse();
        send_samples(32, 1'b0, 1'b0);
        drain(1'b1, fv);
        check_eq("s6_writes", 64'(wr_cnt - w0), 64'd32);
        check_eq("s6_starts", 64'(start_cnt - s0), 64'd1);
        check_image();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fht_stream_ctrl.md
Name: fht_stream_ctrl

Overview:
Frame sequencer in front of fht_top. It accepts a stream of raw ADC samples and writes them round-robin into the four FHT RAM banks. It then pulses the transform start, waits for completion, and streams the result out in natural order, undoing the bit-reversed bank addressing. This replaces bench-side RAM loading and reordering with synthesizable control.

Parameters:
D_BIT, 16, FHT data width; ADC samples are D_BIT-1 bits.
A_BIT, 8, bank address width; BANK_SIZE = 2^A_BIT, frame = 4*BANK_SIZE samples.
RD_LAT, 2, cycles from oFHT_ADDR_RD change to valid iFHT_DATA_x (range 1..3).

Ports:
iCLK  in  1  clock.
iRESET  in  1  reset; one clock; reset is synchronous and active-high.
iGO  in  1  single-cycle request to process one frame.
iADC_VALID  in  1  ADC sample valid.
iADC_DATA  in  D_BIT-1  signed ADC sample.
oADC_READY  out  1  sample accepted when iADC_VALID & oADC_READY.
oFHT_WE  out  4  one-hot bank write enable (to fht_top iWE).
oFHT_DATA  out  D_BIT  sign-extended write data.
oFHT_ADDR_WR  out  A_BIT  write address.
oFHT_START  out  1  transform start pulse.
iFHT_RDY  in  1  fht_top ready (high = idle/finished).
oFHT_ADDR_RD  out  A_BIT  read address, fanned to all four read ports.
iFHT_DATA_0..iFHT_DATA_3  in  D_BIT each  bank read data.
oOUT_VALID  out  1  result word valid.
oOUT_DATA  out  D_BIT  result word.
oOUT_LAST  out  1  marks final word of frame.
iOUT_READY  in  1  downstream ready.
oBUSY  out  1  high in any state except IDLE.
oDONE  out  1  one-cycle pulse when the last word is accepted.

Behaviour:
- Reset: state IDLE; all outputs 0; sample and read counters 0. Reset mid-frame aborts immediately. No further WE or START is issued after the reset cycle. RAM contents are don't-care.
- States: IDLE -> LOAD -> START -> WAIT_LOW -> WAIT_HIGH -> FETCH -> EMIT -> (FETCH | IDLE).
- IDLE: oADC_READY=0. iGO=1 -> LOAD. iGO is ignored in all other states.
- LOAD: oADC_READY=1. Sample counter k (A_BIT+2 bits) advances only on handshake.
  - Accepted sample k is registered: next cycle oFHT_WE = 1<<k[1:0], oFHT_ADDR_WR = k>>2, oFHT_DATA = {msb, iADC_DATA}. WE is 0 otherwise.
  - On acceptance of k = 4*BANK_SIZE-1: oADC_READY drops in the same cycle, counter wraps to 0, go to START.
- START: oFHT_START=1 for exactly one cycle. This occurs after the final WE cycle, never coincident with it. Then WAIT_LOW.
- WAIT_LOW: wait for iFHT_RDY=0, then WAIT_HIGH. WAIT_HIGH: wait for iFHT_RDY=1, then FETCH with read index r=0. A stale high RDY at START therefore cannot end the wait.
- FETCH: oFHT_ADDR_RD = bitrev_A_BIT(r). Hold RD_LAT cycles, then capture all four iFHT_DATA_x into holding registers and go to EMIT.
- EMIT: present holding words bank 0,1,2,3 in order on oOUT_DATA with oOUT_VALID=1.
  - Advance only on iOUT_READY. Data and valid stay stable while stalled.
  - After bank 3 is accepted: if r = BANK_SIZE-1, go to IDLE, pulse oDONE, and assert oOUT_LAST with that final word. Otherwise r+1 and go to FETCH.
- Output order: word n of the frame = bank n[1:0], address bitrev(n>>2).
- oBUSY = (state != IDLE), registered.

Test Plan:
1. A_BIT=3, RD_LAT=2. Reset 3 cycles -> all outputs 0. iGO, then 32 samples of value k with iADC_VALID held -> sample 5 gives WE=4'b0010, ADDR_WR=1, DATA=5. Exactly 32 WE cycles occur, then one START pulse.
2. Negative sample 15'h7FFD (-3) -> oFHT_DATA=16'hFFFD. Sample 15'h3FFF -> 16'h3FFF.
3. FHT model holds RDY=1 for 2 cycles after START, then 0 for 20 cycles, then 1 -> FETCH begins only after the second rising. oFHT_ADDR_RD sequence is 0,4,2,6,1,5,3,7.
4. Model returns data {addr,bank} per bank, iOUT_READY toggling 1/0 each cycle -> 32 words in the order above. No word is dropped or duplicated, and data is stable during stalls. oOUT_LAST and oDONE occur on the word from addr 7 bank 3.
5. Gappy ADC valid (1 of 3 cycles) plus iGO pulsed during LOAD -> still exactly 32 writes, iGO ignored, same RAM image as scenario 1.
6. iRESET asserted after sample 10 in LOAD -> next cycle state IDLE, oADC_READY=0, WE=0, no START. A following iGO plus 32 samples completes a normal frame.
